// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and helpers for the parametrised dual-port SRAM
package sram_pkg;

  typedef enum logic {RDW_OLD, RDW_NEW} rdw_mode_e;

  typedef enum logic {FILL, RUN} sram_state_e;

  function automatic int read_latency(input int out_reg);
    return 1 + out_reg;
  endfunction

endpackage

// File: rtl/sram_fill_seq.sv
// rtl/sram_fill_seq.sv - init sequencer: fills every word with INIT_VAL, then hands
// the write port to the user
module sram_fill_seq
  import sram_pkg::*;
#(
  parameter int                WIDTH    = 32,
  parameter int                DEPTH    = 624,
  parameter int                AW       = $clog2(DEPTH),
  parameter logic [WIDTH-1:0]  INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             wr,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_din
);

  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

  sram_state_e   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          in_range;

  // Writes past the last word can occur when DEPTH is not a power of two
  assign in_range = {1'b0, addr} < DEPTH_W;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready    = 1'b0;
    mem_we   = 1'b0;
    mem_addr = addr;
    mem_din  = din;
    case (state_q)
      FILL: begin
        mem_we   = 1'b1;
        mem_addr = cnt_q;
        mem_din  = INIT_VAL;
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        ready  = 1'b1;
        mem_we = wr & in_range;
        if (clr) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

endmodule

// File: rtl/sram_dp_param.sv
// rtl/sram_dp_param.sv - dual-port state SRAM: port 1 read/write, port 2 read-only,
// selectable read-during-write and optional output register
module sram_dp_param
  import sram_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 624,
  parameter int               OUT_REG  = 0,
  parameter rdw_mode_e        RDW_MODE = RDW_OLD,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int              AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  output logic             ready,
  input  logic             wr,
  input  logic             rd1,
  input  logic [AW-1:0]    Addr1,
  input  logic [WIDTH-1:0] Di,
  input  logic             rd2,
  input  logic [AW-1:0]    Addr2,
  output logic [WIDTH-1:0] Do1,
  output logic [WIDTH-1:0] Do2,
  output logic             vld1,
  output logic             vld2
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_din;

  sram_fill_seq #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AW       (AW),
    .INIT_VAL (INIT_VAL)
  ) u_fill (
    .clk      (clk),
    .nrst     (nrst),
    .clr      (clr),
    .wr       (wr),
    .addr     (Addr1),
    .din      (Di),
    .ready    (ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din)
  );

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
  end

  logic             rd1_en, rd2_en;
  logic [WIDTH-1:0] rdat1, rdat2;

  assign rd1_en = ready & rd1;
  assign rd2_en = ready & rd2;

  // Out-of-range reads return zero; write-first bypass only when selected
  always_comb begin
    rdat1 = '0;
    rdat2 = '0;
    if ({1'b0, Addr1} < DEPTH_W)
      rdat1 = (RDW_MODE == RDW_NEW && wr) ? Di : mem[Addr1];
    if ({1'b0, Addr2} < DEPTH_W)
      rdat2 = (RDW_MODE == RDW_NEW && wr && Addr2 == Addr1) ? Di : mem[Addr2];
  end

  logic [WIDTH-1:0] q1, q2;
  logic             v1, v2;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q1 <= '0;
      q2 <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= rd1_en;
      v2 <= rd2_en;
      if (rd1_en) q1 <= rdat1;
      if (rd2_en) q2 <= rdat2;
    end
  end

  if (read_latency(OUT_REG) == 2) begin : g_oreg
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        Do1  <= '0;
        Do2  <= '0;
        vld1 <= 1'b0;
        vld2 <= 1'b0;
      end else begin
        vld1 <= v1;
        vld2 <= v2;
        if (v1) Do1 <= q1;
        if (v2) Do2 <= q2;
      end
    end
  end else begin : g_direct
    assign Do1  = q1;
    assign Do2  = q2;
    assign vld1 = v1;
    assign vld2 = v2;
  end

endmodule

// File: tb/tb_sram_dp_param.sv
// tb/tb_sram_dp_param.sv - scoreboard bench over three configurations sharing one stimulus
module tb_sram_dp_param;
  import sram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst, clr, wr, rd1, rd2;
  logic [2:0]  Addr1, Addr2;
  logic [31:0] Di;
  logic [2:0]  rdy, v1, v2;
  logic [31:0] do1 [3];
  logic [31:0] do2 [3];

  sram_dp_param #(.WIDTH(32), .DEPTH(8), .OUT_REG(0), .RDW_MODE(RDW_OLD),
                  .INIT_VAL(32'hA5A5_A5A5)) u_a (
    .clk(clk), .nrst(nrst), .clr(clr), .ready(rdy[0]), .wr(wr), .rd1(rd1),
    .Addr1(Addr1), .Di(Di), .rd2(rd2), .Addr2(Addr2), .Do1(do1[0]), .Do2(do2[0]),
    .vld1(v1[0]), .vld2(v2[0]));

  sram_dp_param #(.WIDTH(32), .DEPTH(8), .OUT_REG(1), .RDW_MODE(RDW_NEW),
                  .INIT_VAL(32'h3C3C_C3C3)) u_b (
    .clk(clk), .nrst(nrst), .clr(clr), .ready(rdy[1]), .wr(wr), .rd1(rd1),
    .Addr1(Addr1), .Di(Di), .rd2(rd2), .Addr2(Addr2), .Do1(do1[1]), .Do2(do2[1]),
    .vld1(v1[1]), .vld2(v2[1]));

  sram_dp_param #(.WIDTH(32), .DEPTH(5), .OUT_REG(1), .RDW_MODE(RDW_OLD),
                  .INIT_VAL(32'h5A5A_0F0F)) u_c (
    .clk(clk), .nrst(nrst), .clr(clr), .ready(rdy[2]), .wr(wr), .rd1(rd1),
    .Addr1(Addr1), .Di(Di), .rd2(rd2), .Addr2(Addr2), .Do1(do1[2]), .Do2(do2[2]),
    .vld1(v1[2]), .vld2(v2[2]));

  int          dep   [3] = '{8, 8, 5};
  int          lat   [3] = '{1, 2, 2};
  bit          newm  [3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] initv [3] = '{32'hA5A5_A5A5, 32'h3C3C_C3C3, 32'h5A5A_0F0F};
  logic [31:0] mdl   [3][8];
  int          fc    [3];
  int          cyc, checks, errors;

  typedef struct {
    int          inst;
    int          port;
    logic [31:0] d;
    int          t;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rexp(input int i, input logic [2:0] a, input bit w,
                                       input logic [2:0] a1, input logic [31:0] d);
    if (int'(a) >= dep[i]) return 32'h0;
    if (newm[i] && w && a == a1) return d;
    return mdl[i][a];
  endfunction

  task automatic monitor();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ready[%0d]", i), {31'b0, rdy[i]}, {31'b0, (nrst && fc[i] == dep[i])});
      for (int p = 1; p <= 2; p++) begin
        int          idx;
        bit          ev, gv;
        logic [31:0] dv;
        idx = -1;
        gv  = (p == 1) ? v1[i] : v2[i];
        dv  = (p == 1) ? do1[i] : do2[i];
        foreach (sbq[k]) if (idx < 0 && sbq[k].inst == i && sbq[k].port == p) idx = k;
        ev = (idx >= 0) && (sbq[idx].t == cyc);
        chk($sformatf("vld%0d[%0d]", p, i), {31'b0, gv}, {31'b0, ev});
        if (ev) begin
          if (gv) chk($sformatf("do%0d[%0d]", p, i), dv, sbq[idx].d);
          sbq.delete(idx);
        end
      end
    end
  endtask

  task automatic step(input bit w, input bit r1, input bit r2, input logic [2:0] a1,
                      input logic [2:0] a2, input logic [31:0] d, input bit c);
    wr = w; rd1 = r1; rd2 = r2; Addr1 = a1; Addr2 = a2; Di = d; clr = c;
    for (int i = 0; i < 3; i++) begin
      if (nrst && fc[i] == dep[i]) begin
        if (r1) sbq.push_back(exp_t'{i, 1, rexp(i, a1, w, a1, d), cyc + lat[i]});
        if (r2) sbq.push_back(exp_t'{i, 2, rexp(i, a2, w, a1, d), cyc + lat[i]});
        if (w && int'(a1) < dep[i]) mdl[i][a1] = d;
      end
      if (nrst) begin
        if (c) fc[i] = 0;
        else if (fc[i] < dep[i]) begin
          fc[i]++;
          if (fc[i] == dep[i]) for (int k = 0; k < 8; k++) mdl[i][k] = initv[i];
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    monitor();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 32'h0, 1'b0);
  endtask

  task automatic rst_chk(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_ready[%0d]", tag, i), {31'b0, rdy[i]}, 32'h0);
      chk($sformatf("%s_vld1[%0d]", tag, i), {31'b0, v1[i]}, 32'h0);
      chk($sformatf("%s_vld2[%0d]", tag, i), {31'b0, v2[i]}, 32'h0);
      chk($sformatf("%s_do1[%0d]", tag, i), do1[i], 32'h0);
      chk($sformatf("%s_do2[%0d]", tag, i), do2[i], 32'h0);
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) step(1'b0, 1'b1, 1'b1, 3'(a), 3'(7 - a), 32'h0, 1'b0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    nrst = 1'b1; clr = 1'b0; wr = 1'b0; rd1 = 1'b0; rd2 = 1'b0;
    Addr1 = '0; Addr2 = '0; Di = '0;
    for (int i = 0; i < 3; i++) fc[i] = 0;
    #2 nrst = 1'b0;
    #1 rst_chk("reset");
    repeat (3) idle();
    nrst = 1'b1;
    repeat (10) idle();

    for (int a = 0; a < 8; a++) step(1'b0, 1'b0, 1'b1, 3'd0, 3'(a), 32'h0, 1'b0);

    step(1'b1, 1'b0, 1'b0, 3'd5, 3'd0, 32'h1234_5678, 1'b0);
    step(1'b0, 1'b1, 1'b1, 3'd5, 3'd5, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'd3, 3'd0, 32'h0000_0011, 1'b0);
    step(1'b1, 1'b0, 1'b1, 3'd3, 3'd3, 32'hDEAD_BEEF, 1'b0);
    step(1'b0, 1'b1, 1'b1, 3'd3, 3'd3, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 3'd4, 3'd0, 32'hCAFE_0004, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'd6, 3'd0, 32'hFFFF_FFFF, 1'b0);
    step(1'b0, 1'b1, 1'b1, 3'd6, 3'd6, 32'h0, 1'b0);
    for (int a = 0; a < 5; a++) step(1'b0, 1'b1, 1'b0, 3'(a), 3'd0, 32'h0, 1'b0);

    // clear while running; reads issued with the clear still complete
    step(1'b1, 1'b1, 1'b1, 3'd2, 3'd7, 32'h0000_7777, 1'b1);
    for (int n = 0; n < 10; n++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom, 1'b0);
    read_all();

    // async reset three cycles into a fill, between clock edges
    step(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 32'h0, 1'b1);
    repeat (3) idle();
    nrst = 1'b0;
    sbq.delete();
    for (int i = 0; i < 3; i++) fc[i] = 0;
    #1 rst_chk("async");
    repeat (2) idle();
    nrst = 1'b1;
    repeat (10) idle();
    read_all();

    for (int n = 0; n < 150; n++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 40) == 0));
    repeat (12) idle();
    read_all();
    repeat (4) idle();
    chk("sb_empty", 32'(sbq.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_dp_param.md
Name: sram_dp_param

Overview:
- Parametrised dual-port synchronous SRAM for generator state storage. It is the next generation of the fixed 624x32 state-array memory.
- Port 1 is read/write and port 2 is read-only. Adds configurable width and depth, a selectable read-during-write mode, and an optional output register stage with read-valid flags.
- Adds a built-in initialisation sequencer that fills every word with INIT_VAL after reset or on a clear request. The core sees a known state array before seeding.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 624, number of words (>=2; need not be a power of two).
- AW, $clog2(DEPTH), address width (derived; not overridden).
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
- RDW_MODE, RDW_OLD, port-1/port-2 read-during-write behaviour at the same address: RDW_OLD returns the previous contents; RDW_NEW returns Di (write-first bypass).
- INIT_VAL, '0, WIDTH-bit fill value written by the sequencer.

Ports:
- clk, input, 1, clock; all logic is on posedge.
- nrst, input, 1, asynchronous active-low reset.
- clr, input, 1, single-cycle request to restart the fill sequence.
- ready, output, 1, high when the fill is complete and user accesses are accepted.
- wr, input, 1, port-1 write enable.
- rd1, input, 1, port-1 read enable.
- Addr1, input, AW, port-1 address.
- Di, input, WIDTH, port-1 write data.
- rd2, input, 1, port-2 read enable.
- Addr2, input, AW, port-2 address.
- Do1, output, WIDTH, port-1 read data.
- Do2, output, WIDTH, port-2 read data.
- vld1, output, 1, Do1 holds data for a read issued 1+OUT_REG cycles earlier.
- vld2, output, 1, Do2 holds data for a read issued 1+OUT_REG cycles earlier.

Behaviour:
- Reset and clock: one clock; reset is asynchronous and active-low.
- While nrst=0:
  - ready=0, Do1=Do2=0, vld1=vld2=0.
  - Fill counter is 0; FSM is in FILL.
  - The memory array itself is not reset.
- FSM has two states, FILL and RUN.
  - FILL: each cycle writes INIT_VAL to mem[cnt], then cnt++. When cnt reaches DEPTH-1 and that write completes, the next state is RUN and cnt returns to 0. The fill takes exactly DEPTH cycles after reset deassertion.
  - RUN: ready=1. clr=1 moves the FSM to FILL on the next edge; ready drops in that same edge.
- During FILL:
  - wr, rd1 and rd2 are ignored: no write, and vld stays 0.
  - Reads already in the OUT_REG pipeline still complete.
  - clr during FILL restarts cnt at 0.
- Reset mid-fill: the async clear returns the block to the reset state, and the fill restarts from 0 after release.
- Port-1 write in RUN: mem[Addr1] <= Di on the edge where wr=1.
- Reads (RUN only):
  - rd1 or rd2 captures mem[addr] at the edge.
  - With OUT_REG=0, Do and vld update at that edge.
  - With OUT_REG=1, they pass through one more register.
  - vld is a pulse per read. Do holds its last value when vld=0.
- Read-during-write at the same address (wr and rd on the same Addr):
  - RDW_OLD: Do1 and/or Do2 return the pre-write word.
  - RDW_NEW: Do1 and/or Do2 return Di.
  - This applies to both ports independently.
- Out-of-range address (Addr >= DEPTH, possible when DEPTH is not a power of two):
  - A write is dropped.
  - A read returns 0 with vld=1.
- Simultaneous wr and rd1 on port 1 at different addresses is impossible, since there is a single address. wr=1 with rd1=0 produces no vld1.
- Widths: the fill counter is AW bits. Its comparison against DEPTH-1 is unsigned.

Decomposition:
- Package sram_pkg holds:
  - enum rdw_mode_e {RDW_OLD, RDW_NEW};
  - the FSM state enum sram_state_e {FILL, RUN};
  - a function giving read latency as 1+OUT_REG.
- Sub-module sram_fill_seq contains the FSM, the fill counter, ready, and the fill address/data/write-enable mux.
- The top level contains the array, the read ports, the bypass logic and the optional output stage.

Test Plan:
- Fill after reset: DEPTH=8, INIT_VAL=32'hA5A5_A5A5; release nrst. Required: ready rises exactly 8 cycles later, and reading all 8 addresses on port 2 returns A5A5A5A5 with vld2 pulses.
- Write then read: write 32'h1234_5678 to address 5 via port 1; next cycle rd1 and rd2 at address 5. Required: Do1=Do2=12345678 at latency 1 (OUT_REG=0) and at latency 2 (OUT_REG=1).
- Collision: wr=1, Di=32'hDEAD_BEEF, Addr1=Addr2=3, rd2=1, old word 32'h0000_0011. Required: RDW_OLD gives Do2=00000011; RDW_NEW gives Do2=DEADBEEF.
- Clear mid-run: pulse clr after writes. Required: ready=0 for DEPTH cycles and all user accesses are ignored with no vld; afterwards every word reads INIT_VAL.
- Async reset mid-fill: assert nrst low at fill cycle 3 with no clock edge. Required: outputs go to 0 immediately; after release the full DEPTH-cycle fill repeats.
- DEPTH=5, AW=3, address 6: write 32'hFFFF_FFFF to address 6, then read address 6. Required: Do=0 with vld=1, and addresses 0-4 keep INIT_VAL.
